// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART command path: arbiter state encoding,
// response bytes used by the command decoder, and the default watchdog limit.
package uart_cmd_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BUSY = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  // Response bytes shared with the command decoder
  localparam logic [7:0] ACK   = 8'h55;
  localparam logic [7:0] RESET = 8'hAA;
  localparam logic [7:0] NACK  = 8'hEE;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters / UART transmitter and uart_tx_arbiter.
// slave: the arbiter side. master: the requester and UART side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned REQ_W   = 3
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_pending;
  logic [NUM_REQ-1:0]   req_overflow;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 tx_done;
  logic [REQ_W-1:0]     grant_id;
  logic                 arb_busy;
  logic                 timeout_err;

  modport slave (
    input  req_valid, req_data, tx_busy, tx_done,
    output req_pending, req_overflow, tx_data, tx_start, grant_id, arb_busy, timeout_err
  );

  modport master (
    output req_valid, req_data, tx_busy, tx_done,
    input  req_pending, req_overflow, tx_data, tx_start, grant_id, arb_busy, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first pending requester after last_grant, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned REQ_W   = 3
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [REQ_W-1:0]   last_grant,
  output logic               grant_valid,
  output logic [REQ_W-1:0]   grant_idx
);

  int unsigned        idx;
  logic [NUM_REQ-1:0] shifted;

  // Scan NUM_REQ slots starting at last_grant+1; the first pending slot wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    shifted     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx     = (32'(last_grant) + k) % NUM_REQ;
      shifted = pend >> idx;
      if (!grant_valid && shifted[0]) begin
        grant_valid = 1'b1;
        grant_idx   = REQ_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ strobe-only requesters.
// Each byte is latched in a per-requester hold register, the transmitter is
// granted round-robin, and only one byte is ever in flight.
// Optional watchdog: define UART_TX_TIMEOUT_EN to abort a transfer that never
// sees tx_done within TIMEOUT_CYCLES.
module uart_tx_arbiter
  import uart_cmd_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned REQ_W          = 3,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  if (NUM_REQ < 1 || NUM_REQ > 8 || (1 << REQ_W) < NUM_REQ || TIMEOUT_CYCLES < 1)
  begin : g_param_check
    $error("uart_tx_arbiter: illegal NUM_REQ/REQ_W/TIMEOUT_CYCLES");
  end

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] ovf_q, ovf_d;
  logic [NUM_REQ-1:0] gnt_oh, hold_we;
  logic [7:0]         hold_q [NUM_REQ];
  logic [7:0]         grant_byte;
  logic [7:0]         tx_data_q;
  logic               tx_start_q;
  logic [REQ_W-1:0]   grant_id_q, last_grant_q, grant_idx;
  logic               grant_valid, grant_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_rr (
    .pend        (pend_q),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign grant_fire = (state_q == IDLE) && grant_valid;

  // Capture strobes; a pending byte may only be replaced in the cycle it is granted.
  always_comb begin
    gnt_oh     = '0;
    hold_we    = '0;
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    grant_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt_oh[i] = grant_fire && (grant_idx == REQ_W'(i));
      if (gnt_oh[i]) begin
        pend_d[i]  = 1'b0;
        grant_byte = hold_q[i];
      end
      if (bus.req_valid[i]) begin
        if (!pend_q[i] || gnt_oh[i]) begin
          hold_we[i] = 1'b1;
          pend_d[i]  = 1'b1;
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  // Hold registers, one byte per requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) hold_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (hold_we[i]) hold_q[i] <= bus.req_data[8*i +: 8];
      end
    end
  end

`ifdef UART_TX_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] wd_cnt_q;
  logic            timeout_q;
  logic            timeout_hit;

  // A tx_done in the final cycle still counts as a normal completion.
  assign timeout_hit = (state_q != IDLE) && !bus.tx_done &&
                       (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter restarts at each grant; error flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (grant_fire) begin
        wd_cnt_q <= '0;
      end else if (state_q != IDLE) begin
        wd_cnt_q <= wd_cnt_q + CntW'(1);
      end
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // Transfer sequencing: start pulse, wait for busy and/or done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant_valid) state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_done) begin
          state_d = IDLE;
        end else if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: if (bus.tx_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
`ifdef UART_TX_TIMEOUT_EN
    if (timeout_hit) state_d = IDLE;
`endif
  end

  // State, pending/overflow flags and the registered transmitter interface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      ovf_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      grant_id_q   <= '0;
      last_grant_q <= REQ_W'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      tx_start_q <= grant_fire;
      if (grant_fire) begin
        tx_data_q    <= grant_byte;
        grant_id_q   <= grant_idx;
        last_grant_q <= grant_idx;
      end
    end
  end

  assign bus.req_pending  = pend_q;
  assign bus.req_overflow = ovf_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.arb_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NUM_REQ=2 and TIMEOUT_CYCLES=16.
module tb_uart_tx_arbiter;
  import uart_cmd_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned RW = 3;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .REQ_W(RW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .REQ_W          (RW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [1:0] mask, input logic [7:0] d1, input logic [7:0] d0);
    bus.req_valid = mask;
    bus.req_data  = {d1, d0};
    tick();
    bus.req_valid = '0;
  endtask

  // Called right after the tx_start edge: busy for nbusy cycles, then a done pulse.
  task automatic finish_tx(input int nbusy);
    bus.tx_busy = 1'b1;
    repeat (nbusy) tick();
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic wait_start(input string tag, input logic [2:0] exp_id, input logic [7:0] exp_b);
    int k;
    k = 0;
    while (!bus.tx_start && k < 8) begin
      tick();
      k++;
    end
    check({tag, "_start"}, 32'(bus.tx_start), 32'd1);
    check({tag, "_data"}, 32'(bus.tx_data), 32'(exp_b));
    check({tag, "_id"}, 32'(bus.grant_id), 32'(exp_id));
  endtask

  task automatic quiet(input string tag, input int n);
    int cnt;
    cnt = 0;
    repeat (n) begin
      tick();
      if (bus.tx_start) cnt++;
    end
    check(tag, 32'(cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_busy   = 1'b0;
    bus.tx_done   = 1'b0;
    repeat (3) tick();
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check("rst_arb_busy", 32'(bus.arb_busy), 32'd0);
    check("rst_pending", 32'(bus.req_pending), 32'd0);
    check("rst_overflow", 32'(bus.req_overflow), 32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
    rst = 1'b0;
    tick();

    // Single request: exact latency and one-cycle start pulse
    strobe(2'b01, 8'h00, ACK);
    check("t1_pend", 32'(bus.req_pending), 32'b01);
    check("t1_no_start_yet", 32'(bus.tx_start), 32'd0);
    tick();
    check("t1_start", 32'(bus.tx_start), 32'd1);
    check("t1_data", 32'(bus.tx_data), 32'h55);
    check("t1_id", 32'(bus.grant_id), 32'd0);
    check("t1_busy", 32'(bus.arb_busy), 32'd1);
    check("t1_pend_clr", 32'(bus.req_pending), 32'd0);
    bus.tx_busy = 1'b1;
    tick();
    check("t1_start_1cyc", 32'(bus.tx_start), 32'd0);
    tick();
    tick();
    check("t1_data_held", 32'(bus.tx_data), 32'h55);
    check("t1_id_held", 32'(bus.grant_id), 32'd0);
    check("t1_busy_held", 32'(bus.arb_busy), 32'd1);
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    check("t1_busy_fall", 32'(bus.arb_busy), 32'd0);

    // tx_busy / tx_done while idle are ignored
    bus.tx_busy = 1'b1;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b0;
    check("idle_ign_busy", 32'(bus.arb_busy), 32'd0);
    quiet("idle_ign_start", 3);

    // Simultaneous requests from a fresh reset: 0 then 1, twice
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    strobe(2'b11, NACK, RESET);
    check("t2_pend", 32'(bus.req_pending), 32'b11);
    wait_start("t2_a", 3'd0, RESET);
    check("t2_pend_a", 32'(bus.req_pending), 32'b10);
    finish_tx(2);
    check("t2_idle_gap", 32'(bus.tx_start), 32'd0);
    wait_start("t2_b", 3'd1, NACK);
    finish_tx(2);
    strobe(2'b11, NACK, RESET);
    wait_start("t2_c", 3'd0, RESET);
    finish_tx(1);
    wait_start("t2_d", 3'd1, NACK);
    finish_tx(1);

    // Overflow: second strobe on req1 while its byte is still pending
    strobe(2'b01, 8'h00, 8'h11);
    wait_start("t3_a", 3'd0, 8'h11);
    bus.tx_busy   = 1'b1;
    bus.req_valid = 2'b10;
    bus.req_data  = {8'h01, 8'h00};
    tick();
    bus.req_data  = {8'h02, 8'h00};
    tick();
    bus.req_valid = '0;
    check("t3_ovf", 32'(bus.req_overflow), 32'b10);
    check("t3_pend", 32'(bus.req_pending), 32'b10);
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    wait_start("t3_b", 3'd1, 8'h01);
    finish_tx(1);
    quiet("t3_no_second", 6);
    check("t3_pend_clr", 32'(bus.req_pending), 32'd0);
    check("t3_ovf_sticky", 32'(bus.req_overflow), 32'b10);

    // Fast transmitter: tx_done in WAIT_BUSY without tx_busy
    strobe(2'b11, 8'hB2, 8'hB1);
    tick();
    check("t4_start_a", 32'(bus.tx_start), 32'd1);
    check("t4_data_a", 32'(bus.tx_data), 32'hB1);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    check("t4_idle", 32'(bus.arb_busy), 32'd0);
    check("t4_gap", 32'(bus.tx_start), 32'd0);
    tick();
    check("t4_start_b", 32'(bus.tx_start), 32'd1);
    check("t4_data_b", 32'(bus.tx_data), 32'hB2);
    check("t4_id_b", 32'(bus.grant_id), 32'd1);
    finish_tx(1);

    // Reset during WAIT_DONE with req1 pending
    strobe(2'b11, 8'hC1, 8'hC0);
    tick();
    bus.tx_busy = 1'b1;
    tick();
    check("t5_busy", 32'(bus.arb_busy), 32'd1);
    check("t5_pend", 32'(bus.req_pending), 32'b10);
    rst = 1'b1;
    #1;
    check("t5_tx_start", 32'(bus.tx_start), 32'd0);
    check("t5_tx_data", 32'(bus.tx_data), 32'd0);
    check("t5_grant_id", 32'(bus.grant_id), 32'd0);
    check("t5_arb_busy", 32'(bus.arb_busy), 32'd0);
    check("t5_pending", 32'(bus.req_pending), 32'd0);
    check("t5_overflow", 32'(bus.req_overflow), 32'd0);
    check("t5_timeout", 32'(bus.timeout_err), 32'd0);
    bus.tx_busy = 1'b0;
    tick();
    rst = 1'b0;
    quiet("t5_no_restart", 8);
    check("t5_idle", 32'(bus.arb_busy), 32'd0);

`ifdef UART_TX_TIMEOUT_EN
    // Watchdog: tx_done withheld, abort after 16 cycles in flight
    strobe(2'b01, 8'h00, 8'hD0);
    tick();
    check("t6_start", 32'(bus.tx_start), 32'd1);
    repeat (15) tick();
    check("t6_still_busy", 32'(bus.arb_busy), 32'd1);
    check("t6_no_err_yet", 32'(bus.timeout_err), 32'd0);
    tick();
    check("t6_aborted", 32'(bus.arb_busy), 32'd0);
    check("t6_err", 32'(bus.timeout_err), 32'd1);
    strobe(2'b10, 8'hD1, 8'h00);
    wait_start("t6_next", 3'd1, 8'hD1);
    finish_tx(1);
    check("t6_next_idle", 32'(bus.arb_busy), 32'd0);
    check("t6_err_sticky", 32'(bus.timeout_err), 32'd1);
`else
    // Without the watchdog the arbiter waits indefinitely for tx_done
    strobe(2'b01, 8'h00, 8'hD0);
    tick();
    check("t6_start", 32'(bus.tx_start), 32'd1);
    repeat (20) tick();
    check("t6_still_busy", 32'(bus.arb_busy), 32'd1);
    check("t6_no_err", 32'(bus.timeout_err), 32'd0);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    check("t6_done_idle", 32'(bus.arb_busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between several response sources: the command decoder, a status reporter and future event sources. Each requester issues a one-cycle pulse with a byte and never sees backpressure. The arbiter latches each byte, grants the transmitter round-robin, and sequences tx_start / tx_busy / tx_done so that only one byte is ever in flight.

Parameters:
NUM_REQ, 2, number of requester ports (1..8)
REQ_W, 3, width of grant_id; must satisfy 2**REQ_W >= NUM_REQ
TIMEOUT_CYCLES, 100000, watchdog limit in clk cycles (used only with UART_TX_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester one-cycle strobe; byte valid on req_data
req_data  in  8*NUM_REQ  byte i at bits [8i+7:8i]
req_pending  out  NUM_REQ  byte i latched and not yet granted
req_overflow  out  NUM_REQ  sticky; byte i dropped because holding register was full
tx_data  out  8  byte to the UART TX; held stable from tx_start until tx_done
tx_start  out  1  one-cycle start pulse to the UART TX
tx_busy  in  1  UART TX is shifting
tx_done  in  1  UART TX one-cycle completion pulse
grant_id  out  REQ_W  index of the requester currently or last granted
arb_busy  out  1  high whenever state != IDLE
timeout_err  out  1  sticky watchdog flag; tied 0 without UART_TX_TIMEOUT_EN

Behaviour:
- Reset: all outputs 0; hold registers 0; pend 0; last_grant = NUM_REQ-1, so requester 0 wins first; state IDLE.
- Reset mid-transfer: the in-flight byte and all pending bytes are discarded. tx_start is never re-issued.
- Capture, per requester i, at each posedge:
  - req_valid[i] and pend[i]=0: hold[i]<=byte, pend[i]<=1.
  - req_valid[i] and pend[i]=1, with i granted this same cycle: new byte accepted and pend[i] stays 1.
  - req_valid[i] and pend[i]=1, i not granted: new byte dropped, old byte kept, req_overflow[i]<=1.
- req_pending equals pend. req_overflow is cleared only by rst.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE, with any pend bit set:
  - Search from (last_grant+1) mod NUM_REQ upward with wrap; the first set bit wins and is g.
  - At the same edge: tx_data<=hold[g], tx_start<=1, pend[g]<=0, grant_id<=g, last_grant<=g; go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_start<=0; it is high for exactly one cycle.
  - tx_busy=1 goes to WAIT_DONE.
  - tx_done=1 goes directly to IDLE (covers a fast transmitter).
- WAIT_DONE: tx_done=1 goes to IDLE. tx_busy alone does not end the transfer.
- Latency: req_valid sampled at edge N gives pend=1 after N. tx_start is high in the cycle after edge N+1, if the arbiter was idle.
- Back-to-back: IDLE lasts at least one cycle after tx_done. The next tx_start comes no earlier than two cycles after tx_done.
- Simultaneous requests are served in round-robin order: with NUM_REQ=2 and both pending, grants alternate 0,1,0,1.
- tx_done or tx_busy seen while in IDLE is ignored.

Optional Feature:
UART_TX_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY or WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1 without tx_done: force IDLE, set timeout_err (sticky until rst), drop the byte. pend is not restored.
- Undefined: no counter is instantiated, timeout_err is tied 0, and the arbiter waits indefinitely for tx_done.

Decomposition:
- Package uart_cmd_pkg:
  - arbiter state encoding: IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2
  - response byte constants ACK=8'h55, RESET=8'hAA, NACK=8'hEE, shared with the command decoder
  - default TIMEOUT_CYCLES
- Sub-module rr_arbiter, purely combinational: inputs pend and last_grant; outputs grant_valid and grant_idx. Instantiated once. The FSM, hold registers and watchdog stay in uart_tx_arbiter.

Test Plan:
- Single request: req_valid[0] with 8'h55 while idle -> tx_start high for exactly 1 cycle, 2 cycles after the strobe; tx_data=8'h55 and grant_id=0 held until tx_done; arb_busy falls 1 cycle after tx_done.
- Simultaneous: req_valid=2'b11 with bytes 8'hAA (req0) and 8'hEE (req1) -> transmitted AA then EE. Repeat both requests -> order continues 0,1 (round-robin).
- Overflow: two strobes on req1 (8'h01, 8'h02) while busy with req0 -> req_overflow[1]=1; 8'h01 transmitted, 8'h02 never transmitted.
- Fast TX: tx_done asserted in WAIT_BUSY without tx_busy -> return to IDLE; next pending byte starts 2 cycles later.
- Reset mid-transfer: rst during WAIT_DONE with req1 pending -> all outputs 0; after release no tx_start occurs without a new strobe.
- With UART_TX_TIMEOUT_EN and TIMEOUT_CYCLES=16: tx_done withheld -> timeout_err=1 after 16 cycles, state IDLE; the next request is served normally and timeout_err stays 1.
